// File: rtl/t_ff_seq_pkg.sv
// Shared op-codes and FSM state encoding for the T flip-flop sequencer.
package t_ff_seq_pkg;

    localparam logic [1:0] OP_CLEAR  = 2'd0;
    localparam logic [1:0] OP_LOAD   = 2'd1;
    localparam logic [1:0] OP_COUNT  = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/t_ff_bank.sv
// Bank of WIDTH T flip-flops; each bit flips on a clock edge where its t input is 1.
module t_ff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= q ^ t;
    end

    assign q_bar = ~q;

endmodule

// File: rtl/t_ff_seq_ctrl.sv
// Command sequencer driving a T flip-flop bank (clear / load / count / masked toggle).
// Optional abort input enabled by defining T_FF_SEQ_CTRL_ABORT_EN.
module t_ff_seq_ctrl
    import t_ff_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done,
    output logic             wrap
`ifdef T_FF_SEQ_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    state_t           state, state_next;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] rem;
    logic [WIDTH-1:0] t_bank;
    logic             accept;
    logic             abort_now;
    logic             carry;

    assign accept = (state == IDLE) && cmd_valid;

`ifdef T_FF_SEQ_CTRL_ABORT_EN
    assign abort_now = abort && (state == EXEC);
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = EXEC;
            EXEC:    if (abort_now || rem == LEN_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state == EXEC) || (state == DONE);
        done      = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= OP_CLEAR;
            data_r <= '0;
            rem    <= '0;
            wrap   <= 1'b0;
        end else begin
            wrap <= (state == EXEC) && (op_r == OP_COUNT) && (&q) && !abort_now;
            if (accept) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
                if (cmd_op == OP_CLEAR || cmd_op == OP_LOAD) rem <= LEN_W'(1);
                else if (cmd_len == '0)                      rem <= LEN_W'(1);
                else                                         rem <= cmd_len;
            end else if (state == EXEC) begin
                rem <= abort_now ? '0 : rem - LEN_W'(1);
            end
        end
    end

    // COUNT toggles bit i when all lower bits are one (ripple-carry increment).
    always_comb begin
        t_vec = '0;
        carry = 1'b1;
        if (state == EXEC) begin
            case (op_r)
                OP_CLEAR:  t_vec = q;
                OP_LOAD:   t_vec = q ^ data_r;
                OP_COUNT: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        t_vec[i] = carry;
                        carry    = carry & q[i];
                    end
                end
                OP_TOGGLE: t_vec = data_r;
                default:   t_vec = '0;
            endcase
        end
    end

    assign t_bank = abort_now ? '0 : t_vec;

    t_ff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .t     (t_bank),
        .q     (q),
        .q_bar (q_bar)
    );

endmodule

// File: tb/tb_t_ff_seq_ctrl.sv
// Directed-vector bench for t_ff_seq_ctrl (WIDTH=4); abort checks only with T_FF_SEQ_CTRL_ABORT_EN.
module tb_t_ff_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_data = 4'h0;
    logic [7:0] cmd_len = 8'd0;
    logic [3:0] t_vec, q, q_bar;
    logic       busy, done, wrap;
`ifdef T_FF_SEQ_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    t_ff_seq_ctrl #(
        .WIDTH(4),
        .LEN_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .t_vec     (t_vec),
        .q         (q),
        .q_bar     (q_bar),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
`ifdef T_FF_SEQ_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [7:0] l);
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = l;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input logic [7:0] l);
        issue(op, d, l);
        wait_done(300);
        tick();
    endtask

    initial begin
        int wraps;
        logic [3:0] cnt_exp [5];
        cnt_exp = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", q, 4'h0);
        check("rst_qbar", q_bar, 4'hF);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_tvec", t_vec, 4'h0);
        check("rst_ready", cmd_ready, 1'b1);
        reset = 1'b1;
        tick();

        // LOAD 0xA
        issue(2'd1, 4'hA, 8'd0);
        check("load_busy", busy, 1'b1);
        check("load_ready_lo", cmd_ready, 1'b0);
        check("load_tvec", t_vec, 4'hA);
        tick();
        check("load_q", q, 4'hA);
        check("load_qbar", q_bar, 4'h5);
        check("load_done", done, 1'b1);
        check("load_tvec_done", t_vec, 4'h0);
        tick();
        check("load_done_lo", done, 1'b0);
        check("load_ready_hi", cmd_ready, 1'b1);

        // COUNT len=5 from 0xD
        run_cmd(2'd1, 4'hD, 8'd0);
        check("pre_count_q", q, 4'hD);
        issue(2'd2, 4'h0, 8'd5);
        wraps = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("count_q%0d", i), q, cnt_exp[i]);
            check($sformatf("count_wrap%0d", i), wrap, (i == 2) ? 1'b1 : 1'b0);
            if (wrap) wraps++;
        end
        check("count_done", done, 1'b1);
        check("count_wraps", wraps, 1);
        tick();
        check("count_ready", cmd_ready, 1'b1);

        // TOGGLE 0101 len=3 from 0, then CLEAR
        run_cmd(2'd0, 4'h0, 8'd0);
        check("clear0_q", q, 4'h0);
        issue(2'd3, 4'h5, 8'd3);
        tick(); check("tog_q0", q, 4'h5);
        tick(); check("tog_q1", q, 4'h0);
        tick(); check("tog_q2", q, 4'h5);
        check("tog_done", done, 1'b1);
        tick();
        issue(2'd0, 4'hF, 8'd9);
        tick();
        check("clear_q", q, 4'h0);
        check("clear_done", done, 1'b1);
        tick();

        // COUNT len=0 executes one step
        issue(2'd2, 4'h0, 8'd0);
        tick();
        check("len0_q", q, 4'h1);
        check("len0_done", done, 1'b1);
        tick();

        // cmd_valid held for 8 edges: two COUNT len=2 commands accepted
        cmd_op = 2'd2; cmd_len = 8'd2; cmd_data = 4'h0; cmd_valid = 1'b1;
        tick(); tick();
        check("hold_ready_busy", cmd_ready, 1'b0);
        repeat (6) tick();
        cmd_valid = 1'b0;
        check("hold_q", q, 4'h5);
        check("hold_ready", cmd_ready, 1'b1);

        // reset mid-COUNT
        run_cmd(2'd0, 4'h0, 8'd0);
        issue(2'd2, 4'h0, 8'd100);
        repeat (10) tick();
        check("mid_q", q, 4'hA);
        reset = 1'b0;
        #1;
        check("mrst_q", q, 4'h0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ready", cmd_ready, 1'b1);
        tick();
        check("mrst_done", done, 1'b0);
        reset = 1'b1;
        tick();
        check("post_rst_done", done, 1'b0);
        check("post_rst_q", q, 4'h0);
        issue(2'd1, 4'h3, 8'd0);
        tick();
        check("post_rst_load_q", q, 4'h3);
        check("post_rst_load_done", done, 1'b1);
        tick();

`ifdef T_FF_SEQ_CTRL_ABORT_EN
        // abort after 3 steps of COUNT len=20
        run_cmd(2'd0, 4'h0, 8'd0);
        issue(2'd2, 4'h0, 8'd20);
        repeat (3) tick();
        check("abort_pre_q", q, 4'h3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_q", q, 4'h3);
        check("abort_done", done, 1'b1);
        tick();
        check("abort_done_lo", done, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_q_hold", q, 4'h3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
